// File: rtl/svc_pkg.sv
// Shared types and default sizing for the service scheduler.
package svc_pkg;

    localparam int unsigned SVC_DT_SZ = 4;
    localparam int unsigned SVC_CNTER = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2
    } svc_state_t;

endpackage

// File: rtl/service_scheduler_if.sv
// FIFO-side and counter-status signals of the service scheduler.
// Optional feature macro: SVC_STATS_EN adds the 8-bit served counter.
interface service_scheduler_if
    import svc_pkg::*;
#(
    parameter int unsigned DT_SZ = SVC_DT_SZ,
    parameter int unsigned CNTER = SVC_CNTER
);

    logic                     empty;
    logic [DT_SZ-1:0]         qn;
    logic [DT_SZ-1:0]         qt;
    logic                     re;
    logic [CNTER-1:0]         busy;
    logic [CNTER*DT_SZ-1:0]   cur_num;
    logic [CNTER-1:0]         done;
`ifdef SVC_STATS_EN
    logic [7:0]               served;
`endif

`ifdef SVC_STATS_EN
    modport master (input empty, qn, qt, output re, busy, cur_num, done, served);
    modport slave  (output empty, qn, qt, input re, busy, cur_num, done, served);
`else
    modport master (input empty, qn, qt, output re, busy, cur_num, done);
    modport slave  (output empty, qn, qt, input re, busy, cur_num, done);
`endif

endinterface

// File: rtl/svc_timer.sv
// One service counter: service-time countdown, held customer number, busy/done flags.
module svc_timer #(
    parameter int unsigned DT_SZ = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_c,
    input  logic [DT_SZ-1:0] qn,
    input  logic [DT_SZ-1:0] qt,
    output logic             busy,
    output logic             done,
    output logic [DT_SZ-1:0] cur_num
);

    logic [DT_SZ-1:0] timer;

    // Load (zero service time becomes one cycle), then count down; busy mirrors timer != 0.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            timer   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cur_num <= '0;
        end else begin
            done <= 1'b0;
            if (load_c) begin
                timer   <= (qt == '0) ? DT_SZ'(1) : qt;
                cur_num <= qn;
                busy    <= 1'b1;
            end else if (timer != '0) begin
                timer <= timer - DT_SZ'(1);
                busy  <= (timer != DT_SZ'(1));
                done  <= (timer == DT_SZ'(1));
            end
        end
    end

endmodule

// File: rtl/service_scheduler.sv
// Round-robin dispatcher from a customer FIFO onto CNTER service counters.
// Optional feature macro: SVC_STATS_EN (saturating served-customer count).
// Note: rst_n is asynchronous and active-high in this codebase.
module service_scheduler
    import svc_pkg::*;
#(
    parameter int unsigned DT_SZ = SVC_DT_SZ,
    parameter int unsigned CNTER = SVC_CNTER
) (
    input  logic          clk,
    input  logic          rst_n,
    service_scheduler_if.master bus
);

    localparam int unsigned IW = (CNTER > 1) ? $clog2(CNTER) : 1;

    svc_state_t       state;
    logic [IW-1:0]    g;
    logic [IW-1:0]    rr_ptr;
    logic             re_q;
    logic [IW-1:0]    grant_c;
    logic             grant_ok_c;

    logic             busy_a [CNTER];
    logic             done_a [CNTER];
    logic [DT_SZ-1:0] num_a  [CNTER];

    // First free counter scanning upward from rr_ptr+1 with wrap; smallest offset wins.
    always_comb begin
        int unsigned idx;
        grant_ok_c = 1'b0;
        grant_c    = '0;
        idx        = 0;
        for (int unsigned k = CNTER; k >= 1; k--) begin
            idx = (32'(rr_ptr) + k) % CNTER;
            if (!busy_a[idx]) begin
                grant_ok_c = 1'b1;
                grant_c    = IW'(idx);
            end
        end
    end

    // Dispatch FSM: IDLE picks a counter, FETCH pops the FIFO, LOAD hands data to the counter.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= IDLE;
            re_q   <= 1'b0;
            g      <= '0;
            rr_ptr <= IW'(CNTER - 1);
        end else begin
            re_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.empty && grant_ok_c) begin
                        g     <= grant_c;
                        re_q  <= 1'b1;
                        state <= FETCH;
                    end
                end
                FETCH: state <= LOAD;
                LOAD: begin
                    rr_ptr <= g;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // One timer per counter; only the granted one loads during LOAD.
    for (genvar i = 0; i < int'(CNTER); i++) begin : g_ctr
        svc_timer #(.DT_SZ(DT_SZ)) u_timer (
            .clk     (clk),
            .rst_n   (rst_n),
            .load_c  ((state == LOAD) && (g == IW'(i))),
            .qn      (bus.qn),
            .qt      (bus.qt),
            .busy    (busy_a[i]),
            .done    (done_a[i]),
            .cur_num (num_a[i])
        );
    end

    // Pack per-counter status onto the bus.
    always_comb begin
        bus.busy    = '0;
        bus.done    = '0;
        bus.cur_num = '0;
        for (int unsigned i = 0; i < CNTER; i++) begin
            bus.busy[i]                  = busy_a[i];
            bus.done[i]                  = done_a[i];
            bus.cur_num[i*DT_SZ +: DT_SZ] = num_a[i];
        end
    end

    assign bus.re = re_q;

`ifdef SVC_STATS_EN
    logic [7:0] served_q;

    // Saturating count of dispatched customers.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            served_q <= '0;
        end else if ((state == LOAD) && (served_q != 8'hFF)) begin
            served_q <= served_q + 8'd1;
        end
    end

    assign bus.served = served_q;
`endif

endmodule

// File: tb/tb_service_scheduler.sv
// Scoreboard bench for service_scheduler: FIFO model, grant/number/duration checks.
module tb_service_scheduler;
    import svc_pkg::*;

    localparam int unsigned DT_SZ = SVC_DT_SZ;
    localparam int unsigned CNTER = SVC_CNTER;

    typedef struct {
        int unsigned num;
        int unsigned t;
    } cust_t;

    typedef struct {
        int unsigned ctr;
        int unsigned num;
        int unsigned dur;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    service_scheduler_if #(.DT_SZ(DT_SZ), .CNTER(CNTER)) bus ();

    service_scheduler #(.DT_SZ(DT_SZ), .CNTER(CNTER)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cust_t       fifo_q [$];
    exp_t        sb_q [$];
    int unsigned re_times [$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned last_done0 = 0;
    bit          want_done_re = 1'b0;
    int unsigned bcnt    [CNTER];
    int unsigned exp_dur [CNTER];
    int unsigned exp_num [CNTER];
    logic [CNTER-1:0] prev_busy = '0;
    logic [CNTER-1:0] prev_done = '0;
    cust_t       c_m;
    exp_t        e_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic enqueue(input int unsigned num, input int unsigned t, input int unsigned ctr);
        cust_t c;
        exp_t  e;
        c.num = num;
        c.t   = t;
        e.ctr = ctr;
        e.num = num;
        e.dur = (t == 0) ? 1 : t;
        fifo_q.push_back(c);
        sb_q.push_back(e);
    endtask

    // FIFO model and output monitor, all on the falling edge.
    initial begin
        bus.empty = 1'b1;
        bus.qn    = '0;
        bus.qt    = '0;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            prev_busy = '0;
            prev_done = '0;
        end else begin
            if (bus.re) begin
                re_times.push_back(cyc);
                if (fifo_q.size() > 0) begin
                    c_m    = fifo_q.pop_front();
                    bus.qn = DT_SZ'(c_m.num);
                    bus.qt = DT_SZ'(c_m.t);
                end
                if (want_done_re) begin
                    check("done_to_re", cyc - last_done0, 1);
                    want_done_re = 1'b0;
                end
            end
            if (&bus.busy) check("stall_re", 32'(bus.re), 0);
            for (int i = 0; i < int'(CNTER); i++) begin
                if (bus.busy[i] && !prev_busy[i]) begin
                    if (sb_q.size() == 0) begin
                        check("sb_underflow", 1, 0);
                    end else begin
                        e_m = sb_q.pop_front();
                        check("grant_ctr", i, e_m.ctr);
                        check("load_num", 32'(bus.cur_num[i*DT_SZ +: DT_SZ]), e_m.num);
                        exp_dur[i] = e_m.dur;
                        exp_num[i] = e_m.num;
                        bcnt[i]    = 1;
                    end
                end else if (bus.busy[i]) begin
                    bcnt[i]++;
                end
                if (bus.done[i]) begin
                    check("busy_len", bcnt[i], exp_dur[i]);
                    check("hold_num", 32'(bus.cur_num[i*DT_SZ +: DT_SZ]), exp_num[i]);
                    check("done_width", 32'(prev_done[i]), 0);
                    if (i == 0) last_done0 = cyc;
                end
            end
            prev_busy = bus.busy;
            prev_done = bus.done;
        end
        bus.empty = (fifo_q.size() == 0);
    end

    task automatic do_reset();
        rst_n = 1'b1;
        fifo_q.delete();
        sb_q.delete();
        want_done_re = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_re", 32'(bus.re), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_cur_num", 32'(bus.cur_num), 0);
`ifdef SVC_STATS_EN
        check("rst_served", 32'(bus.served), 0);
`endif
        rst_n = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((sb_q.size() != 0 || fifo_q.size() != 0 || bus.busy != '0) && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        #1;
        check("drain_timeout", 32'(k < budget), 1);
        check("sb_left", sb_q.size(), 0);
    endtask

    initial begin
        int k;

        // Single customer from reset: one-cycle re latency, counter 0, 3 busy cycles.
        do_reset();
        enqueue(10, 3, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("re_latency", 32'(bus.re), 1);
        wait_idle(100);
        check("s1_num", 32'(bus.cur_num[DT_SZ-1:0]), 10);
`ifdef SVC_STATS_EN
        check("s1_served", 32'(bus.served), 1);
`endif

        // Three back-to-back customers: counters 0,1,2, one re every 3 cycles.
        do_reset();
        re_times.delete();
        enqueue(11, 2, 0);
        enqueue(12, 4, 1);
        enqueue(13, 1, 2);
        wait_idle(200);
        check("s2_re_count", re_times.size(), 3);
        if (re_times.size() == 3) begin
            check("s2_gap01", re_times[1] - re_times[0], 3);
            check("s2_gap12", re_times[2] - re_times[1], 3);
        end

        // All counters busy: hold off until counter 0 finishes, then dispatch to it.
        do_reset();
        enqueue(1, 9, 0);
        enqueue(2, 9, 1);
        enqueue(3, 9, 2);
        enqueue(4, 2, 0);
        k = 0;
        while (bus.busy != '1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        #1;
        check("s3_all_busy", 32'(k < 200), 1);
        want_done_re = 1'b1;
        wait_idle(300);
        check("s3_done_to_re_seen", 32'(want_done_re), 0);

        // Zero service time served in one cycle; grant wraps from counter 2 to 0.
        do_reset();
        enqueue(5, 1, 0);
        enqueue(6, 1, 1);
        enqueue(7, 0, 2);
        enqueue(8, 2, 0);
        wait_idle(200);
        check("s4_ctr0_num", 32'(bus.cur_num[DT_SZ-1:0]), 8);

        // Reset during FETCH discards the transfer and clears all timers at once.
        do_reset();
        enqueue(1, 8, 0);
        k = 0;
        while (!bus.busy[0] && k < 100) begin
            @(negedge clk);
            k++;
        end
        enqueue(9, 5, 1);
        k = 0;
        while (!bus.re && k < 100) begin
            @(negedge clk);
            k++;
        end
        check("s5_fetch_seen", 32'(k < 100), 1);
        #1;
        rst_n = 1'b1;
        #1;
        check("s5_rst_re", 32'(bus.re), 0);
        check("s5_rst_busy", 32'(bus.busy), 0);
`ifdef SVC_STATS_EN
        check("s5_rst_served", 32'(bus.served), 0);
`endif
        do_reset();
        enqueue(14, 2, 0);
        wait_idle(100);
`ifdef SVC_STATS_EN
        check("s5_served_one", 32'(bus.served), 1);
`endif
        check("s5_num", 32'(bus.cur_num[DT_SZ-1:0]), 14);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/service_scheduler.md
SERVICE_SCHEDULER -- requirements
Module: service_scheduler

Interface
REQ-001 Parameter DT_SZ SHALL be defined: default 4, width of customer number and service time.
REQ-002 Parameter CNTER SHALL be defined: default 3, number of service counters (2..8).
REQ-003 clk SHALL be: input, 1 bit, rising-edge clock.
REQ-004 rst_n SHALL be the reset: input, 1 bit, asynchronous, active-high (block held in reset while rst_n=1).
REQ-005 empty SHALL be: input, 1 bit, customer FIFO empty flag.
REQ-006 qn SHALL be: input, DT_SZ bits, FIFO customer number, valid the cycle after re.
REQ-007 qt SHALL be: input, DT_SZ bits, FIFO service time in cycles, valid the cycle after re.
REQ-008 re SHALL be: output, 1 bit, FIFO read strobe, single-cycle pulse.
REQ-009 busy SHALL be: output, CNTER bits, bit i=1 while counter i is serving.
REQ-010 cur_num SHALL be: output, CNTER*DT_SZ bits, customer number held by each counter; counter i occupies bits [i*DT_SZ +: DT_SZ].
REQ-011 done SHALL be: output, CNTER bits, one-cycle pulse when counter i finishes service.

Function
REQ-012 The FSM SHALL have three states: IDLE, FETCH, LOAD.
REQ-013 IDLE SHALL go to FETCH when empty=0 and at least one busy bit is 0, latching grant index g; otherwise it SHALL remain in IDLE.
REQ-014 g SHALL be chosen round-robin: first free counter scanning upward from rr_ptr+1, wrapping from CNTER-1 to 0.
REQ-015 re SHALL be registered and equal 1 exactly during the FETCH cycle; FETCH SHALL go to LOAD unconditionally.
REQ-016 In LOAD, counter g SHALL capture qn into cur_num[g] and its timer SHALL load qt; rr_ptr SHALL become g; next state SHALL be IDLE.
REQ-017 qt=0 SHALL be loaded as 1.
REQ-018 Each counter timer SHALL decrement by 1 per cycle while nonzero; busy[i] SHALL equal (timer_i != 0), so a loaded counter is busy starting the cycle after LOAD.
REQ-019 done[i] SHALL pulse in the cycle the timer goes from 1 to 0; cur_num[i] SHALL hold its value after done.
REQ-020 A counter whose timer reaches 0 in cycle N SHALL first be eligible for grant in IDLE during cycle N+1.
REQ-021 Throughput SHALL be at most one dispatch per 3 cycles; the minimum empty=0-to-re latency SHALL be 1 cycle.
REQ-022 empty rising during FETCH or LOAD SHALL NOT abort the in-flight transfer.
REQ-023 All-busy with empty=0 SHALL keep the block in IDLE with re=0 and no FIFO pop.

Reset
REQ-024 While rst_n=1: state=IDLE, re=0, busy=0, done=0, cur_num=0, all timers=0, rr_ptr=CNTER-1 (first grant goes to counter 0).
REQ-025 Reset asserted mid-FETCH or mid-LOAD SHALL discard the transfer and clear all timers immediately.

Configuration
REQ-026 Macro SVC_STATS_EN SHALL control served-customer statistics.
REQ-027 With SVC_STATS_EN defined, output served (8 bits) SHALL increment on every LOAD, saturate at 255, and reset to 0.
REQ-028 Without SVC_STATS_EN defined, port served and its counter SHALL be absent.

Structure
REQ-029 Package svc_pkg SHALL hold the FSM state enum (IDLE/FETCH/LOAD) and the default DT_SZ/CNTER constants.
REQ-030 Sub-module svc_timer (one per counter, via generate) SHALL contain the load/decrement timer, cur_num register, busy and done logic.

Verification
REQ-031 After reset, empty=0, qn=10, qt=3, busy all 0: re pulses 1 cycle after IDLE; counter 0 gets cur_num=10; busy[0]=1 for 3 cycles; done[0] pulses once.
REQ-032 Three customers (11,2), (12,4), (13,1) queued back-to-back: grants go to counters 0, 1, 2 in order, one re per 3 cycles.
REQ-033 All counters busy with empty=0: re stays 0 until the first done; the next customer then goes to that counter one cycle later.
REQ-034 Customer with qt=0: served 1 cycle, done pulses; rr_ptr wrap from counter 2 grants counter 0 next.
REQ-035 rst_n=1 asserted during FETCH: re, busy, and all timers return to 0 immediately; with SVC_STATS_EN defined, served=0 and increments to 1 after one dispatch.
